delay_line_pipe: RTL and testbench

//  Parametrised multi-stage delay line: successor to the single D flip-flop with async reset.

---
 rtl/delay_pkg.sv | 18 +
 rtl/dff_stage.sv | 24 ++
 rtl/delay_line_pipe.sv | 92 +++++++++
 tb/tb_delay_line_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared defaults, the stage record layout and the tap clamp helper for delay_line_pipe.
package delay_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // Stage record as laid out in a default-width build: valid bit above the data.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

    // Out-of-range tap requests read the last stage instead.
    function automatic int unsigned clamp_tap(input int unsigned sel, input int unsigned depth);
        return (sel >= depth) ? depth - 1 : sel;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline register: async active-low reset, synchronous clear beating enable.
module dff_stage #(
    parameter int unsigned W = 9
) (
    input  logic         CLK,
    input  logic         n_res,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register with clear taking priority over load.
    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/delay_line_pipe.sv
// Programmable-tap delay line: DEPTH chained stages with valid bits, stall, flush
// and an occupancy counter.
module delay_line_pipe
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             n_res,
    input  logic [WIDTH-1:0] D,
    input  logic             v_in,
    input  logic             en,
    input  logic             flush,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid,
    output logic             tap_err,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rec_t;

    rec_t             stage_q [DEPTH];
    rec_t             stage_in [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    int unsigned      tap_idx;

    // Stage 0 takes the input; every later stage takes its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_in[k] = '{valid: v_in, data: D};
        end else begin : g_body
            assign stage_in[k] = stage_q[k-1];
        end

        dff_stage #(
            .W(WIDTH + 1)
        ) u_stage (
            .CLK  (CLK),
            .n_res(n_res),
            .en   (en),
            .clr  (flush),
            .d    (stage_in[k]),
            .q    (stage_q[k])
        );
    end

    // Occupancy tracks entries in minus entries falling off the end.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(v_in) - CNT_W'(stage_q[DEPTH-1].valid);
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Tap mux, clamped to the last stage for out-of-range selects.
    always_comb begin
        tap_idx = clamp_tap(32'(tap_sel), DEPTH);
        Q       = '0;
        q_valid = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (tap_idx == k) begin
                Q       = stage_q[k].data;
                q_valid = stage_q[k].valid;
            end
        end
    end

    assign tap_err = (32'(tap_sel) >= DEPTH);
    assign count   = count_q;
    assign empty   = (count_q == '0);

endmodule

// File: tb/tb_delay_line_pipe.sv
// Scoreboard bench for delay_line_pipe: a DEPTH=4 instance on the main tap and a
// DEPTH=3 instance parked on an out-of-range tap, both fed the same stream.
module tb_delay_line_pipe;

    logic       CLK = 1'b0;
    logic       n_res;
    logic [7:0] D;
    logic       v_in;
    logic       en;
    logic       flush;
    logic [1:0] tap_sel;
    logic [7:0] Q;
    logic       q_valid;
    logic       tap_err;
    logic [2:0] count;
    logic       empty;

    logic [1:0] tap3;
    logic [7:0] q3;
    logic       qv3;
    logic       err3;
    logic [1:0] count3;
    logic       empty3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic       qv;
        logic [2:0] cnt;
        logic       emp;
        logic       err;
        logic [7:0] q3;
        logic       qv3;
        logic       err3;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] m4[$];  // {valid, data}, index 0 = newest
    logic [8:0] m3[$];

    delay_line_pipe #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .CLK    (CLK),
        .n_res  (n_res),
        .D      (D),
        .v_in   (v_in),
        .en     (en),
        .flush  (flush),
        .tap_sel(tap_sel),
        .Q      (Q),
        .q_valid(q_valid),
        .tap_err(tap_err),
        .count  (count),
        .empty  (empty)
    );

    delay_line_pipe #(
        .WIDTH(8),
        .DEPTH(3)
    ) dut3 (
        .CLK    (CLK),
        .n_res  (n_res),
        .D      (D),
        .v_in   (v_in),
        .en     (en),
        .flush  (flush),
        .tap_sel(tap3),
        .Q      (q3),
        .q_valid(qv3),
        .tap_err(err3),
        .count  (count3),
        .empty  (empty3)
    );

    initial forever #5 CLK = ~CLK;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic model_clear();
        m4 = {9'h0, 9'h0, 9'h0, 9'h0};
        m3 = {9'h0, 9'h0, 9'h0};
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the post-edge expectation.
    task automatic step(input logic [7:0] d, input logic v, input logic e, input logic f,
                        input logic [1:0] t);
        exp_t x;
        int   n;
        @(negedge CLK);
        D = d; v_in = v; en = e; flush = f; tap_sel = t;
        if (f) begin
            model_clear();
        end else if (e) begin
            m4.push_front({v, d}); void'(m4.pop_back());
            m3.push_front({v, d}); void'(m3.pop_back());
        end
        n = 0;
        foreach (m4[i]) n += int'(m4[i][8]);
        x.q    = m4[t][7:0];
        x.qv   = m4[t][8];
        x.cnt  = 3'(n);
        x.emp  = (n == 0);
        x.err  = 1'b0;
        x.q3   = m3[2][7:0];
        x.qv3  = m3[2][8];
        x.err3 = 1'b1;
        exp_q.push_back(x);
    endtask

    // Monitor: compare each post-edge sample against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("Q", 32'(Q), 32'(x.q));
                check("q_valid", 32'(q_valid), 32'(x.qv));
                check("count", 32'(count), 32'(x.cnt));
                check("empty", 32'(empty), 32'(x.emp));
                check("tap_err", 32'(tap_err), 32'(x.err));
                check("q3", 32'(q3), 32'(x.q3));
                check("qv3", 32'(qv3), 32'(x.qv3));
                check("tap_err3", 32'(err3), 32'(x.err3));
            end
        end
    end

    initial begin
        n_res = 1'b0; D = 8'h00; v_in = 1'b0; en = 1'b0; flush = 1'b0;
        tap_sel = 2'd0; tap3 = 2'd3;
        model_clear();
        #2;
        check("rst_Q", 32'(Q), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        @(negedge CLK);
        n_res = 1'b1;

        // Single-stage tap, then fill every stage with A5.
        for (int i = 0; i < 5; i++) step(8'hA5, 1'b1, 1'b1, 1'b0, 2'd0);

        // Async reset between edges, then D toggling while held in reset.
        @(posedge CLK);
        #3;
        n_res = 1'b0;
        #1;
        check("arst_Q", 32'(Q), 32'h0);
        check("arst_qv", 32'(q_valid), 32'h0);
        check("arst_count", 32'(count), 32'h0);
        check("arst_q3", 32'(q3), 32'h0);
        en = 1'b1; v_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            D = 8'(i * 8'h3C + 8'h5A);
            #6;
            check("arst_hold_Q", 32'(Q), 32'h0);
            check("arst_hold_count", 32'(count), 32'h0);
        end
        en = 1'b0; v_in = 1'b0;
        model_clear();
        @(negedge CLK);
        n_res = 1'b1;

        // Full delay through the last tap.
        step(8'h11, 1'b1, 1'b1, 1'b0, 2'd3);
        step(8'h22, 1'b1, 1'b1, 1'b0, 2'd3);
        step(8'h33, 1'b1, 1'b1, 1'b0, 2'd3);
        step(8'h44, 1'b1, 1'b1, 1'b0, 2'd3);
        step(8'h55, 1'b0, 1'b1, 1'b0, 2'd3);

        // Stall with D changing, then resume.
        step(8'h66, 1'b1, 1'b0, 1'b0, 2'd3);
        step(8'h77, 1'b1, 1'b0, 1'b0, 2'd3);
        step(8'h88, 1'b1, 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 3; i++) step(8'h90 + 8'(i), 1'b1, 1'b1, 1'b0, 2'd3);

        // Flush beats enable; FF must never surface at any tap.
        step(8'hFF, 1'b1, 1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1, 1'b0, 2'(i));

        // Randomized traffic with tap changes mid-stream.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
